// File: rtl/icache_nway_param_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
package icache_nway_param_pkg;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  localparam int unsigned DataW     = 32;
  localparam int unsigned WordBytes = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Field width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_nway_param_if.sv
// Fetch-side and refill-side bus of the instruction cache.
interface icache_nway_param_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 20
);
  logic [ADDR_W-1:0] PC;
  logic              pc_valid;
  logic              inv;
  logic [31:0]       Instr;
  logic              HitWrite;
  logic              mm_req;
  logic [ADDR_W-1:0] mm_addr;
  logic              mm_rvalid;
  logic [31:0]       mm_rdata;
  logic [CNT_W-1:0]  CNT_HIT;
  logic [CNT_W-1:0]  CNT_MISS;

  modport master (
    output PC, pc_valid, inv, mm_rvalid, mm_rdata,
    input  Instr, HitWrite, mm_req, mm_addr, CNT_HIT, CNT_MISS
  );
  modport slave (
    input  PC, pc_valid, inv, mm_rvalid, mm_rdata,
    output Instr, HitWrite, mm_req, mm_addr, CNT_HIT, CNT_MISS
  );
endinterface

// File: rtl/icache_nway_param_lru.sv
// True-LRU age array: per set, one age per way; the way aged WAYS-1 is the victim.
module icache_nway_param_lru
  import icache_nway_param_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 2,
  localparam int unsigned WAY_WI = width_of(WAYS),
  localparam int unsigned SET_WI = width_of(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SET_WI-1:0] set,
  input  logic [WAY_WI-1:0] way,
  input  logic              update,
  output logic [WAY_WI-1:0] victim
);

  logic [WAY_WI-1:0] ages_q [SETS][WAYS];
  logic [WAY_WI-1:0] old_age;

  assign old_age = ages_q[set][way];

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_q[set][w] == WAY_WI'(WAYS - 1)) victim = WAY_WI'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) ages_q[s][w] <= WAY_WI'(w);
      end
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_WI'(w) == way) ages_q[set][w] <= '0;
        else if (ages_q[set][w] < old_age) ages_q[set][w] <= ages_q[set][w] + WAY_WI'(1);
      end
    end
  end

endmodule

// File: rtl/icache_nway_param.sv
// N-way set-associative instruction cache with whole-block refill, true LRU,
// invalidate-all and saturating hit/miss counters.
module icache_nway_param
  import icache_nway_param_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 2,
  parameter int unsigned WPB    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 20
) (
  input logic                CLK,
  input logic                RESET,
  icache_nway_param_if.slave bus
);

  localparam int unsigned OFF_W   = clog2(WordBytes * WPB);
  localparam int unsigned IDX_W   = clog2(SETS);
  localparam int unsigned TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned SET_WI  = width_of(SETS);
  localparam int unsigned WAY_WI  = width_of(WAYS);
  localparam int unsigned WORD_WI = width_of(WPB);

  state_e              state_q, state_d;
  logic [WORD_WI-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0]   blk_q, blk_d;
  logic                inv_pend_q, inv_pend_d;
  logic                replay_q, replay_d;
  logic [CNT_W-1:0]    cnt_hit_q, cnt_miss_q;
  logic [DataW-1:0]    buf_q [WPB];
  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q [SETS][WAYS];
  logic [DataW-1:0]    data_q [SETS][WAYS][WPB];

  logic [TAG_W-1:0]    tag, blk_tag;
  logic [SET_WI-1:0]   idx, blk_idx, lru_set;
  logic [WORD_WI-1:0]  word;
  logic                hit;
  logic [WAY_WI-1:0]   hit_way, fill_way, lru_victim, lru_way;
  logic                hit_inc, miss_inc, fill, inv_now, lru_upd, cap;
  logic                hit_write, req;
  logic [DataW-1:0]    instr;

  assign tag     = TAG_W'(bus.PC >> (OFF_W + IDX_W));
  assign idx     = SET_WI'((bus.PC >> OFF_W) & ADDR_W'(SETS - 1));
  assign word    = WORD_WI'((bus.PC >> 2) & ADDR_W'(WPB - 1));
  assign blk_tag = TAG_W'(blk_q >> (OFF_W + IDX_W));
  assign blk_idx = SET_WI'((blk_q >> OFF_W) & ADDR_W'(SETS - 1));

  // Descending scans so the lowest-index match wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_WI'(w);
      end
    end
  end

  always_comb begin
    fill_way = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[blk_idx][w]) fill_way = WAY_WI'(w);
    end
  end

  assign lru_set = (state_q == StWrite) ? blk_idx : idx;

  icache_nway_param_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk    (CLK),
    .rst    (RESET),
    .set    (lru_set),
    .way    (lru_way),
    .update (lru_upd),
    .victim (lru_victim)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    blk_d      = blk_q;
    inv_pend_d = inv_pend_q;
    replay_d   = replay_q;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    fill       = 1'b0;
    inv_now    = 1'b0;
    lru_upd    = 1'b0;
    lru_way    = hit_way;
    cap        = 1'b0;
    req        = 1'b0;
    hit_write  = 1'b0;
    instr      = '0;
    unique case (state_q)
      StIdle: begin
        hit_write = !bus.pc_valid || hit;
        inv_now   = bus.inv;
        if (bus.pc_valid && hit) begin
          instr    = data_q[idx][hit_way][word];
          lru_upd  = 1'b1;
          hit_inc  = !replay_q;
          replay_d = 1'b0;
        end else if (bus.pc_valid) begin
          miss_inc = 1'b1;
          blk_d    = bus.PC & ~ADDR_W'(WordBytes * WPB - 1);
          beat_d   = '0;
          state_d  = StRefill;
        end
      end
      StRefill: begin
        req        = 1'b1;
        inv_pend_d = inv_pend_q | bus.inv;
        if (bus.mm_rvalid) begin
          cap    = 1'b1;
          beat_d = beat_q + WORD_WI'(1);
          if (beat_q == WORD_WI'(WPB - 1)) state_d = StWrite;
        end
      end
      StWrite: begin
        fill       = 1'b1;
        lru_upd    = 1'b1;
        lru_way    = fill_way;
        inv_now    = inv_pend_q | bus.inv;
        inv_pend_d = 1'b0;
        replay_d   = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      blk_q      <= '0;
      inv_pend_q <= 1'b0;
      replay_q   <= 1'b0;
      cnt_hit_q  <= '0;
      cnt_miss_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      blk_q      <= blk_d;
      inv_pend_q <= inv_pend_d;
      replay_q   <= replay_d;
      if (hit_inc && (cnt_hit_q != '1)) cnt_hit_q <= cnt_hit_q + CNT_W'(1);
      if (miss_inc && (cnt_miss_q != '1)) cnt_miss_q <= cnt_miss_q + CNT_W'(1);
      if (fill) valid_q[blk_idx][fill_way] <= 1'b1;
      // Invalidate overrides the fill so a pending inv also kills the new line.
      if (inv_now) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (cap) buf_q[beat_q] <= bus.mm_rdata;
    if (fill) begin
      tag_q[blk_idx][fill_way] <= blk_tag;
      for (int i = 0; i < WPB; i++) data_q[blk_idx][fill_way][i] <= buf_q[i];
    end
  end

  assign bus.HitWrite = hit_write & ~RESET;
  assign bus.Instr    = RESET ? '0 : instr;
  assign bus.mm_req   = req;
  assign bus.mm_addr  = blk_q;
  assign bus.CNT_HIT  = cnt_hit_q;
  assign bus.CNT_MISS = cnt_miss_q;

endmodule

// File: tb/tb_icache_nway_param.sv
// Bench for icache_nway_param (2 ways, 2 sets, 2 words per block) with a memory model
// answering every refill cycle and a scoreboard of expected fetch words.
module tb_icache_nway_param;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  icache_nway_param_if #(.ADDR_W(32), .CNT_W(20)) bus ();

  icache_nway_param #(
    .WAYS   (2),
    .SETS   (2),
    .WPB    (2),
    .ADDR_W (32),
    .CNT_W  (20)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a & ~32'h3);
  endfunction

  // Main memory model: one word per cycle while a refill is requested.
  int unsigned beat;
  logic        stray;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) beat <= 0;
    else if (!bus.mm_req) beat <= 0;
    else if (bus.mm_rvalid) beat <= beat + 1;
  end
  assign bus.mm_rvalid = bus.mm_req | stray;
  assign bus.mm_rdata  = stray ? 32'hDEAD_BEEF : mem_word(bus.mm_addr + 4 * beat);

  // Scoreboard: every served fetch pops one expected word.
  always @(negedge CLK) begin
    if (!RESET && bus.pc_valid && bus.HitWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL instr: unexpected serve of %h at pc %h", bus.Instr, bus.PC);
      end else begin
        chk("instr", bus.Instr, exp_q.pop_front());
      end
    end
  end

  // Issue one fetch; inv_at selects the cycle (0 = request cycle) in which inv is high.
  task automatic fetch(input logic [31:0] addr, input int inv_at, output int stalls);
    @(posedge CLK); #1;
    bus.PC       = addr;
    bus.pc_valid = 1'b1;
    bus.inv      = (inv_at == 0);
    exp_q.push_back(mem_word(addr));
    stalls = 0;
    forever begin
      @(negedge CLK);
      if (bus.HitWrite) break;
      stalls++;
      if (stalls > 40) begin
        n_checks++;
        n_errors++;
        $display("FAIL fetch timeout: pc %h still stalled after %0d cycles, required under 40",
                 addr, stalls);
        exp_q.delete();
        break;
      end
      @(posedge CLK); #1;
      bus.inv = (inv_at == stalls);
    end
    @(posedge CLK); #1;
    bus.pc_valid = 1'b0;
    bus.inv      = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] addr, input int inv_at,
                           input int exp_stalls, input int exp_hits, input int exp_miss);
    int st;
    fetch(addr, inv_at, st);
    chk({name, " stalls"}, st, exp_stalls);
    chk({name, " hits"}, 32'(bus.CNT_HIT), exp_hits);
    chk({name, " misses"}, 32'(bus.CNT_MISS), exp_miss);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          stalls;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vecs [12];
  logic [4:0] exp_hw;
  logic [4:0] exp_req;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Fill pattern across idx0 exercises true-LRU eviction; idx1 rows cover the other set.
    vecs[0]  = '{32'h04, 0, 1, 1};
    vecs[1]  = '{32'h10, 4, 1, 2};
    vecs[2]  = '{32'h20, 4, 1, 3};
    vecs[3]  = '{32'h00, 4, 1, 4};
    vecs[4]  = '{32'h10, 4, 1, 5};
    vecs[5]  = '{32'h00, 0, 2, 5};
    vecs[6]  = '{32'h20, 4, 2, 6};
    vecs[7]  = '{32'h04, 0, 3, 6};
    vecs[8]  = '{32'h14, 4, 3, 7};
    vecs[9]  = '{32'h08, 4, 3, 8};
    vecs[10] = '{32'h0C, 0, 4, 8};
    vecs[11] = '{32'h00, 0, 5, 8};
    exp_hw  = 5'b10000;
    exp_req = 5'b00110;

    RESET        = 1'b1;
    bus.PC       = '0;
    bus.pc_valid = 1'b0;
    bus.inv      = 1'b0;
    stray        = 1'b0;
    #1;
    chk("reset HitWrite", 32'(bus.HitWrite), 0);
    chk("reset Instr", bus.Instr, 0);
    chk("reset mm_req", 32'(bus.mm_req), 0);
    chk("reset CNT_HIT", 32'(bus.CNT_HIT), 0);
    chk("reset CNT_MISS", 32'(bus.CNT_MISS), 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Cold miss timing, cycle by cycle.
    @(posedge CLK); #1;
    bus.PC       = 32'h00;
    bus.pc_valid = 1'b1;
    exp_q.push_back(mem_word(32'h00));
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("cold c%0d HitWrite", c), 32'(bus.HitWrite), 32'(exp_hw[c]));
      chk($sformatf("cold c%0d mm_req", c), 32'(bus.mm_req), 32'(exp_req[c]));
      if (exp_req[c]) chk($sformatf("cold c%0d mm_addr", c), bus.mm_addr, 32'h00);
    end
    @(posedge CLK); #1;
    bus.pc_valid = 1'b0;
    chk("cold CNT_MISS", 32'(bus.CNT_MISS), 1);
    chk("cold CNT_HIT", 32'(bus.CNT_HIT), 0);

    for (int i = 0; i < 12; i++) begin
      fetch_chk($sformatf("vec%0d", i), vecs[i].pc, -1, vecs[i].stalls, vecs[i].hits,
                vecs[i].misses);
    end

    // inv alongside a hit: served, then the line is gone.
    fetch_chk("inv hit", 32'h0C, 0, 0, 6, 8);
    fetch_chk("after inv", 32'h0C, -1, 4, 6, 9);

    // Standalone inv pulse in IDLE.
    @(posedge CLK); #1 bus.inv = 1'b1;
    @(posedge CLK); #1 bus.inv = 1'b0;
    fetch_chk("inv pulse", 32'h00, -1, 4, 6, 10);

    // inv during refill kills the fresh line, so the replay misses and refills again.
    fetch_chk("inv refill", 32'h10, 1, 8, 6, 12);
    fetch_chk("post inv refill", 32'h00, -1, 4, 6, 13);

    // Reset after the first refill beat.
    @(posedge CLK); #1;
    bus.PC       = 32'h20;
    bus.pc_valid = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("midreset mm_req", 32'(bus.mm_req), 0);
    chk("midreset HitWrite", 32'(bus.HitWrite), 0);
    chk("midreset CNT_HIT", 32'(bus.CNT_HIT), 0);
    chk("midreset CNT_MISS", 32'(bus.CNT_MISS), 0);
    bus.pc_valid = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    fetch_chk("post reset", 32'h20, -1, 4, 0, 1);

    // Stray mm_rvalid in IDLE must not disturb anything.
    @(posedge CLK); #1 stray = 1'b1;
    repeat (3) @(posedge CLK);
    #1 stray = 1'b0;
    chk("stray mm_req", 32'(bus.mm_req), 0);
    chk("stray CNT_MISS", 32'(bus.CNT_MISS), 1);
    fetch_chk("stray hit", 32'h24, -1, 0, 1, 1);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
